axi_slave_mem: RTL and testbench
================================

# axi_slave_mem

AXI4 slave endpoint with an internal word-addressed memory. It is the responder counterpart to the write/read control FSMs of the AXI master, and it sits on the far side of the bus from the master as the bench/system target. Independent write (AW/W/B) and read (AR/R) state machines handle one outstanding transaction per direction, using FIXED and INCR bursts of 32-bit beats. Error cases return SLVERR or DECERR responses.

## Interface
- addr_width, 32, AXI address width
- data_width, 32, AXI data width (only 32 supported; WSTRB is 4 bits)
- mem_aw, 8, log2 of memory depth in words (default 256 words = 1 KB)
- AClk  in  1  clock; all logic on rising edge
- ARstn  in  1  asynchronous, active-low reset
- AWID  in  4  write transaction ID
- AWADDR  in  addr_width  write start byte address
- AWLEN  in  8  beats minus 1
- AWSIZE  in  3  beat size
- AWBURST  in  2  burst type
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWLOCK  in  2, AWCACHE  in  2, AWPROT  in  3  accepted and ignored
- WDATA  in  32  write data
- WSTRB  in  4  byte enables
- WLAST  in  1  last beat marker
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BID  out  4  response ID (= captured AWID)
- BRESP  out  2  write response
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- ARID  in  4  read transaction ID
- ARADDR  in  addr_width  read start byte address
- ARLEN  in  8  beats minus 1
- ARSIZE  in  3  beat size
- ARBURST  in  2  burst type
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARLOCK  in  2, ARCACHE  in  2, ARPROT  in  3  ignored
- RID  out  4  read ID (= captured ARID)
- RDATA  out  32  read data
- RRESP  out  2  read response
- RLAST  out  1  last read beat
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready

## Operation
- Reset: every output is 0 while ARstn is low. Both FSMs go to IDLE. Memory contents are not reset. Asserting reset in mid-burst aborts the burst and produces no response.
- Memory word index = addr[mem_aw+1:2]. An address is in range if addr < 4·2^mem_aw.
- Burst rules:
  - FIXED: the address stays constant for every beat.
  - INCR: the address increases by 4 per beat.
  - WRAP (2'b10) and reserved (2'b11) bursts get SLVERR.
  - Any AWSIZE/ARSIZE other than 3'b010 gets SLVERR.
  - The 4 KB boundary is not checked.
- Response precedence per burst: SLVERR (burst/size) > DECERR (any beat out of range) > OKAY.
- Write FSM, W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: AWREADY=1. An AW handshake captures ID, address, length, burst and size-check into the beat counter.
  - W_DATA: WREADY=1. On each W handshake, bytes with WSTRB set are written only if the burst is not SLVERR and the beat address is in range. Out-of-range beats are discarded and flag DECERR.
  - W_DATA exit: after beat AWLEN+1. A WLAST value that disagrees with the beat count forces SLVERR; the beat count still governs the exit.
  - W_RESP: BVALID=1 with BID/BRESP held stable until BREADY.
- Read FSM, R_IDLE → R_DATA → R_IDLE:
  - R_IDLE: ARREADY=1.
  - R_DATA: RVALID=1; RLAST=1 on beat ARLEN+1.
  - RRESP is evaluated per beat: SLVERR for the whole burst, or DECERR for out-of-range beats.
  - RDATA = 0 on any error beat.
  - The beat advances only on an R handshake. RDATA/RRESP/RLAST stay stable while RVALID=1 and RREADY=0.
- Write and read run concurrently. A read and a write to the same word on the same edge return the old data (no bypass).

## Timing
- AWREADY/ARREADY are registered and rise on the first edge after ARstn goes high.
- AW handshake at edge N: AWREADY is low from N, WREADY is high from N.
- W throughput: one beat per cycle.
- BVALID rises on the edge after the last W handshake. AWREADY returns the edge after the B handshake.
- AR handshake at edge N: RVALID is high from N, i.e. valid in cycle N+1.
- R throughput: one beat per cycle while RREADY=1. ARREADY returns the edge after the RLAST handshake.
- AWLEN=0 gives a single beat. The beat counter is 8 bits, so the maximum burst is 256 beats.

## Configuration
- AXI_SLV_RD_PIPE_EN:
  - Defined: memory reads are registered. Each read beat spends one cycle with RVALID=0 (fetch) before RVALID=1, so first data arrives at N+2 and throughput is one beat per 2 cycles.
  - Undefined: combinational memory read, timing as above.

## Test plan
- INCR write AWADDR=0x10, AWLEN=3, WDATA 0xA0..0xA3, WSTRB=4'hF → BRESP=OKAY, BID=AWID. An INCR read of the same range → RDATA 0xA0..0xA3, RLAST on beat 4 only.
- Write 0x11223344 to 0x0, then WSTRB=4'b0101 with 0xAABBCCDD → a read returns 0x11BB33DD.
- FIXED write AWADDR=0x20, AWLEN=2, data 1,2,3 → reading 0x20 returns 3.
- Error bursts:
  - AWADDR=0x3FC, AWLEN=1 (second beat out of range) → BRESP=DECERR, word 0xFF is written.
  - ARBURST=WRAP → RRESP=SLVERR with RDATA=0 on all beats.
  - AWSIZE=1 → SLVERR, memory unchanged.
- Read with RREADY toggling 1/0, ARLEN=7 → 8 beats, no data dropped or duplicated, outputs stable while stalled. Write with BREADY low for 5 cycles → BVALID held and AWREADY stays 0.
- ARstn pulsed low during beat 2 of a 4-beat write → all outputs 0. After release, AWREADY=1 and a new write completes OKAY.

Source files
------------

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave endpoint backed by a word-addressed internal memory.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst per
// direction, FIXED and INCR bursts of 32-bit beats, SLVERR/DECERR error responses.
//
// Ports:
//   AClk, ARstn                       clock, asynchronous active-low reset
//   AW*  (ID/ADDR/LEN/SIZE/BURST/VALID/READY, LOCK/CACHE/PROT ignored)  write address
//   W*   (DATA/STRB/LAST/VALID/READY) write data
//   B*   (ID/RESP/VALID/READY)        write response
//   AR*  (ID/ADDR/LEN/SIZE/BURST/VALID/READY, LOCK/CACHE/PROT ignored)  read address
//   R*   (ID/DATA/RESP/LAST/VALID/READY) read data
//
// Build option: define AXI_SLV_RD_PIPE_EN to register the memory read; each read
// beat then spends one fetch cycle with RVALID low before it is presented.
module axi_slave_mem #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned data_width = 32,
    parameter int unsigned mem_aw     = 8
) (
    input  logic                    AClk,
    input  logic                    ARstn,
    // write address channel
    input  logic [3:0]              AWID,
    input  logic [addr_width-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic [1:0]              AWLOCK,
    input  logic [1:0]              AWCACHE,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    // write data channel
    input  logic [data_width-1:0]   WDATA,
    input  logic [data_width/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    // write response channel
    output logic [3:0]              BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    // read address channel
    input  logic [3:0]              ARID,
    input  logic [addr_width-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic [1:0]              ARLOCK,
    input  logic [1:0]              ARCACHE,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    // read data channel
    output logic [3:0]              RID,
    output logic [data_width-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int unsigned mem_depth = 1 << mem_aw;
    localparam int unsigned strb_w    = data_width / 8;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [addr_width-1:0] addr_step = addr_width'(4);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_DATA  = 2'd1;
`ifdef AXI_SLV_RD_PIPE_EN
    localparam logic [1:0] R_FETCH = 2'd2;
`endif

    // Byte address lies inside the memory window.
    function automatic logic in_range(input logic [addr_width-1:0] a);
        return (a >> (mem_aw + 2)) == '0;
    endfunction

    function automatic logic [mem_aw-1:0] word_idx(input logic [addr_width-1:0] a);
        return a[mem_aw+1:2];
    endfunction

    // SLVERR outranks DECERR.
    function automatic logic [1:0] resp_of(input logic slv, input logic dec);
        if (slv)      return RESP_SLVERR;
        else if (dec) return RESP_DECERR;
        else          return RESP_OKAY;
    endfunction

    logic unused_ok;
    assign unused_ok = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT};

    logic [data_width-1:0] mem [mem_depth];

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    logic [1:0]            w_state, w_next;
    logic [addr_width-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic                  w_incr, w_slverr, w_lasterr, w_decerr;
    logic                  aw_hs, w_hs, b_hs, aw_bad;
    logic                  w_last_beat, mem_we, w_slv_fin, w_dec_fin;

    // Write next-state and handshake decode.
    always_comb begin
        w_next      = w_state;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        b_hs        = 1'b0;
        aw_bad      = AWBURST[1] || (AWSIZE != SIZE_4B);
        w_last_beat = (w_cnt == w_len);
        mem_we      = 1'b0;
        w_slv_fin   = w_slverr || w_lasterr || (WLAST != w_last_beat);
        w_dec_fin   = w_decerr || !in_range(w_addr);
        case (w_state)
            W_IDLE: begin
                if (AWVALID && AWREADY) begin
                    aw_hs  = 1'b1;
                    w_next = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && WREADY) begin
                    w_hs   = 1'b1;
                    mem_we = !w_slverr && in_range(w_addr);
                    if (w_last_beat) w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (BVALID && BREADY) begin
                    b_hs   = 1'b1;
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write state register.
    always_ff @(posedge AClk or negedge ARstn) begin
        if (!ARstn) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write channel outputs and burst bookkeeping.
    always_ff @(posedge AClk or negedge ARstn) begin
        if (!ARstn) begin
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BID       <= '0;
            BRESP     <= RESP_OKAY;
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_incr    <= 1'b0;
            w_slverr  <= 1'b0;
            w_lasterr <= 1'b0;
            w_decerr  <= 1'b0;
        end else begin
            AWREADY <= (w_next == W_IDLE);
            WREADY  <= (w_next == W_DATA);
            BVALID  <= (w_next == W_RESP);
            if (aw_hs) begin
                BID       <= AWID;
                w_addr    <= AWADDR;
                w_len     <= AWLEN;
                w_cnt     <= '0;
                w_incr    <= (AWBURST == BURST_INCR);
                w_slverr  <= aw_bad;
                w_lasterr <= 1'b0;
                w_decerr  <= 1'b0;
            end
            if (w_hs) begin
                w_cnt     <= 8'(w_cnt + 8'd1);
                w_lasterr <= w_lasterr || (WLAST != w_last_beat);
                w_decerr  <= w_dec_fin;
                if (w_incr) w_addr <= w_addr + addr_step;
                if (w_last_beat) BRESP <= resp_of(w_slv_fin, w_dec_fin);
            end
            if (b_hs) BRESP <= RESP_OKAY;
        end
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge AClk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(strb_w); b++) begin
                if (WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    logic [1:0]            r_state, r_next;
    logic [addr_width-1:0] r_addr, r_next_addr, ld_addr;
    logic [7:0]            r_len, r_cnt;
    logic                  r_incr, r_slverr;
    logic                  ar_hs, r_hs, ar_bad;
    logic                  ld, ld_slv, ld_last, ld_err;
    logic [data_width-1:0] rd_word;

    // Read next-state; 'ld' loads the R output registers for the next beat.
    always_comb begin
        r_next      = r_state;
        ar_hs       = 1'b0;
        r_hs        = 1'b0;
        ar_bad      = ARBURST[1] || (ARSIZE != SIZE_4B);
        r_next_addr = r_incr ? (r_addr + addr_step) : r_addr;
        ld          = 1'b0;
        ld_addr     = r_addr;
        ld_slv      = r_slverr;
        ld_last     = 1'b0;
`ifdef AXI_SLV_RD_PIPE_EN
        case (r_state)
            R_IDLE: begin
                if (ARVALID && ARREADY) begin
                    ar_hs  = 1'b1;
                    r_next = R_FETCH;
                end
            end
            R_FETCH: begin
                ld      = 1'b1;
                ld_last = (r_cnt == r_len);
                r_next  = R_DATA;
            end
            R_DATA: begin
                if (RVALID && RREADY) begin
                    r_hs   = 1'b1;
                    r_next = RLAST ? R_IDLE : R_FETCH;
                end
            end
            default: r_next = R_IDLE;
        endcase
`else
        case (r_state)
            R_IDLE: begin
                if (ARVALID && ARREADY) begin
                    ar_hs   = 1'b1;
                    ld      = 1'b1;
                    ld_addr = ARADDR;
                    ld_slv  = ar_bad;
                    ld_last = (ARLEN == 8'd0);
                    r_next  = R_DATA;
                end
            end
            R_DATA: begin
                if (RVALID && RREADY) begin
                    r_hs = 1'b1;
                    if (RLAST) begin
                        r_next = R_IDLE;
                    end else begin
                        ld      = 1'b1;
                        ld_addr = r_next_addr;
                        ld_last = (8'(r_cnt + 8'd1) == r_len);
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
`endif
        ld_err = ld_slv || !in_range(ld_addr);
    end

    assign rd_word = mem[word_idx(ld_addr)];

    // Read state register.
    always_ff @(posedge AClk or negedge ARstn) begin
        if (!ARstn) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read channel outputs; R payload is held in registers so it stays stable under stall.
    always_ff @(posedge AClk or negedge ARstn) begin
        if (!ARstn) begin
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RID      <= '0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
            RLAST    <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_incr   <= 1'b0;
            r_slverr <= 1'b0;
        end else begin
            ARREADY <= (r_next == R_IDLE);
            RVALID  <= (r_next == R_DATA);
            if (ar_hs) begin
                RID      <= ARID;
                r_addr   <= ARADDR;
                r_len    <= ARLEN;
                r_cnt    <= '0;
                r_incr   <= (ARBURST == BURST_INCR);
                r_slverr <= ar_bad;
            end
            if (r_hs) begin
                if (RLAST) begin
                    RDATA <= '0;
                    RRESP <= RESP_OKAY;
                    RLAST <= 1'b0;
                end else begin
                    r_addr <= r_next_addr;
                    r_cnt  <= 8'(r_cnt + 8'd1);
                end
            end
            if (ld) begin
                RDATA <= ld_err ? '0 : rd_word;
                RRESP <= resp_of(ld_slv, !in_range(ld_addr));
                RLAST <= ld_last;
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem: INCR/FIXED bursts, strobes,
// SLVERR/DECERR cases, R/B back-pressure and reset in mid-burst.
module tb_axi_slave_mem;

    logic        AClk, ARstn;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]  AWBURST, ARBURST, AWLOCK, ARLOCK, AWCACHE, ARCACHE, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [3:0]  WSTRB;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    int          rd_n;
    logic [3:0]  rd_id;
    logic [1:0]  wr_resp;
    logic [3:0]  wr_id;

    axi_slave_mem dut (
        .AClk(AClk), .ARstn(ARstn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial AClk = 1'b0;
    always #5 AClk = ~AClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All outputs packed, so a reset check is a single compare.
    function automatic logic [31:0] ctl_outs();
        return {16'h0, AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP, BID, RID};
    endfunction

    // Write burst: data = base+i, constant strobe; optional B back-pressure and bad WLAST.
    task automatic axi_wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                          input logic [3:0] strb, input int bdelay, input logic bad_last,
                          output logic [1:0] resp, output logic [3:0] bid);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge AClk); n++; end
        check("aw_ready", 32'(AWREADY), 32'd1);
        @(negedge AClk);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA  = base + 32'(i);
            WSTRB  = strb;
            WLAST  = (i == int'(len)) ^ (bad_last && i == 0);
            WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin @(negedge AClk); n++; end
            check("w_ready", 32'(WREADY), 32'd1);
            @(negedge AClk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0;
        while (!BVALID && n < 50) begin @(negedge AClk); n++; end
        check("b_valid", 32'(BVALID), 32'd1);
        for (int k = 0; k < bdelay; k++) begin
            check("b_held", 32'(BVALID), 32'd1);
            check("aw_blocked", 32'(AWREADY), 32'd0);
            @(negedge AClk);
        end
        resp = BRESP; bid = BID;
        BREADY = 1'b1;
        @(negedge AClk);
        BREADY = 1'b0;
    endtask

    // Read burst into rd_* arrays; with toggle, RREADY alternates and stalled beats are checked for stability.
    task automatic axi_rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic toggle);
        int n;
        int cyc;
        logic        stalled;
        logic [31:0] h_data;
        logic [2:0]  h_ctl;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge AClk); n++; end
        check("ar_ready", 32'(ARREADY), 32'd1);
        @(negedge AClk);
        ARVALID = 1'b0;
        rd_n = 0; cyc = 0; stalled = 1'b0; h_data = '0; h_ctl = '0;
        while (rd_n < int'(len) + 1 && cyc < 2000) begin
            RREADY = toggle ? ~cyc[0] : 1'b1;
            if (stalled && RVALID) begin
                check("r_stall_data", RDATA, h_data);
                check("r_stall_ctl", 32'({RRESP, RLAST}), 32'(h_ctl));
            end
            stalled = 1'b0;
            if (RVALID && RREADY) begin
                rd_data[rd_n] = RDATA; rd_resp[rd_n] = RRESP; rd_last[rd_n] = RLAST;
                rd_id = RID;
                rd_n++;
            end else if (RVALID) begin
                stalled = 1'b1; h_data = RDATA; h_ctl = {RRESP, RLAST};
            end
            @(negedge AClk);
            cyc++;
        end
        RREADY = 1'b0;
        check("r_beats", 32'(rd_n), 32'(int'(len) + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARstn = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        AWLOCK = '0; AWCACHE = '0; AWPROT = '0; ARLOCK = '0; ARCACHE = '0; ARPROT = '0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // Reset: everything low while ARstn is low, readies rise after release.
        #2 ARstn = 1'b0;
        #1 check("rst_ctl_async", ctl_outs(), 32'd0);
        repeat (3) @(negedge AClk);
        check("rst_ctl", ctl_outs(), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        ARstn = 1'b1;
        @(negedge AClk);
        check("rst_awready", 32'(AWREADY), 32'd1);
        check("rst_arready", 32'(ARREADY), 32'd1);

        // INCR write 0x10..0x1C then read back.
        axi_wr(4'd5, 32'h10, 8'd3, 3'b010, 2'b01, 32'hA0, 4'hF, 0, 1'b0, wr_resp, wr_id);
        check("incr_bresp", 32'(wr_resp), 32'd0);
        check("incr_bid", 32'(wr_id), 32'd5);
        axi_rd(4'd9, 32'h10, 8'd3, 3'b010, 2'b01, 1'b0);
        check("incr_rid", 32'(rd_id), 32'd9);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_rdata%0d", i), rd_data[i], 32'hA0 + 32'(i));
            check($sformatf("incr_rresp%0d", i), 32'(rd_resp[i]), 32'd0);
            check($sformatf("incr_rlast%0d", i), 32'(rd_last[i]), (i == 3) ? 32'd1 : 32'd0);
        end

        // Byte strobes.
        axi_wr(4'd1, 32'h0, 8'd0, 3'b010, 2'b01, 32'h11223344, 4'hF, 0, 1'b0, wr_resp, wr_id);
        axi_wr(4'd2, 32'h0, 8'd0, 3'b010, 2'b01, 32'hAABBCCDD, 4'b0101, 0, 1'b0, wr_resp, wr_id);
        check("strb_bresp", 32'(wr_resp), 32'd0);
        axi_rd(4'd3, 32'h0, 8'd0, 3'b010, 2'b01, 1'b0);
        check("strb_rdata", rd_data[0], 32'h11BB33DD);
        check("strb_rlast", 32'(rd_last[0]), 32'd1);

        // FIXED write: last beat wins.
        axi_wr(4'd4, 32'h20, 8'd2, 3'b010, 2'b00, 32'd1, 4'hF, 0, 1'b0, wr_resp, wr_id);
        check("fixed_bresp", 32'(wr_resp), 32'd0);
        axi_rd(4'd4, 32'h20, 8'd0, 3'b010, 2'b01, 1'b0);
        check("fixed_rdata", rd_data[0], 32'd3);

        // Second beat past the top of memory: DECERR, first beat still lands in word 0xFF.
        axi_wr(4'd6, 32'h3FC, 8'd1, 3'b010, 2'b01, 32'hDEAD0001, 4'hF, 0, 1'b0, wr_resp, wr_id);
        check("oob_bresp", 32'(wr_resp), 32'd3);
        check("oob_bid", 32'(wr_id), 32'd6);
        axi_rd(4'd7, 32'h3FC, 8'd1, 3'b010, 2'b01, 1'b0);
        check("oob_rdata0", rd_data[0], 32'hDEAD0001);
        check("oob_rresp0", 32'(rd_resp[0]), 32'd0);
        check("oob_rdata1", rd_data[1], 32'd0);
        check("oob_rresp1", 32'(rd_resp[1]), 32'd3);
        check("oob_rlast1", 32'(rd_last[1]), 32'd1);

        // WRAP read: SLVERR with zero data on every beat.
        axi_rd(4'd8, 32'h10, 8'd3, 3'b010, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_rresp%0d", i), 32'(rd_resp[i]), 32'd2);
            check($sformatf("wrap_rdata%0d", i), rd_data[i], 32'd0);
        end

        // Bad AWSIZE: SLVERR and memory untouched.
        axi_wr(4'd10, 32'h10, 8'd0, 3'b001, 2'b01, 32'h55, 4'hF, 0, 1'b0, wr_resp, wr_id);
        check("size_bresp", 32'(wr_resp), 32'd2);
        axi_rd(4'd10, 32'h10, 8'd0, 3'b010, 2'b01, 1'b0);
        check("size_unchanged", rd_data[0], 32'hA0);

        // WLAST on the wrong beat.
        axi_wr(4'd11, 32'h60, 8'd1, 3'b010, 2'b01, 32'h70, 4'hF, 0, 1'b1, wr_resp, wr_id);
        check("wlast_bresp", 32'(wr_resp), 32'd2);

        // B back-pressure for 5 cycles, then 8-beat read under RREADY toggling.
        axi_wr(4'd12, 32'h40, 8'd7, 3'b010, 2'b01, 32'hC0, 4'hF, 5, 1'b0, wr_resp, wr_id);
        check("bp_bresp", 32'(wr_resp), 32'd0);
        check("bp_bid", 32'(wr_id), 32'd12);
        axi_rd(4'd13, 32'h40, 8'd7, 3'b010, 2'b01, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tog_rdata%0d", i), rd_data[i], 32'hC0 + 32'(i));
            check($sformatf("tog_rlast%0d", i), 32'(rd_last[i]), (i == 7) ? 32'd1 : 32'd0);
        end

        // Reset during beat 2 of a 4-beat write.
        AWID = 4'd14; AWADDR = 32'h80; AWLEN = 8'd3; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b1;
        for (int n = 0; n < 50 && !AWREADY; n++) @(negedge AClk);
        @(negedge AClk);
        AWVALID = 1'b0;
        WDATA = 32'hE0; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
        check("abort_wready", 32'(WREADY), 32'd1);
        @(negedge AClk);
        WDATA = 32'hE1;
        #2 ARstn = 1'b0;
        #1 check("abort_ctl", ctl_outs(), 32'd0);
        check("abort_rdata", RDATA, 32'd0);
        WVALID = 1'b0;
        repeat (2) @(negedge AClk);
        check("abort_hold", ctl_outs(), 32'd0);
        ARstn = 1'b1;
        @(negedge AClk);
        check("abort_awready", 32'(AWREADY), 32'd1);
        axi_wr(4'd15, 32'h80, 8'd3, 3'b010, 2'b01, 32'hF0, 4'hF, 0, 1'b0, wr_resp, wr_id);
        check("post_rst_bresp", 32'(wr_resp), 32'd0);
        check("post_rst_bid", 32'(wr_id), 32'd15);
        axi_rd(4'd1, 32'h8C, 8'd0, 3'b010, 2'b01, 1'b0);
        check("post_rst_rdata", rd_data[0], 32'hF3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
